// File: rtl/stack_arb_pkg.sv
// Shared constants for the two-requester LIFO arbiter: FSM encoding,
// op codes and default sizing.
package stack_arb_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 16;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/stack_arbiter_if.sv
// Requester-facing bundle of the stack arbiter: requests, grants,
// responses and stack status.
interface stack_arbiter_if
  import stack_arb_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
);
  localparam int AW = $clog2(DEPTH);

  logic [1:0]    req;
  logic [1:0]    op;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    gnt;
  logic [1:0]    ack;
  logic [1:0]    nack;
  logic [DW-1:0] rdata;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  modport master (
    output req, op, wdata0, wdata1,
    input  gnt, ack, nack, rdata, count, full, empty
  );

  modport slave (
    input  req, op, wdata0, wdata1,
    output gnt, ack, nack, rdata, count, full, empty
  );

endinterface

// File: rtl/lifo_stack.sv
// Byte-wide LIFO storage with single-cycle push/pop, registered read data
// and registered occupancy.
module lifo_stack
  import stack_arb_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   count_q;
  logic [AW:0]   count_m1;
  logic [DW-1:0] dout_q;
  logic          do_push;
  logic          do_pop;

  assign full_o   = (count_q == FULL_CNT);
  assign empty_o  = (count_q == '0);
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign count_m1 = count_q - 1'b1;

  // NOTE: storage has no reset; only the occupancy counter defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[count_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      dout_q  <= '0;
    end else if (do_push) begin
      count_q <= count_q + 1'b1;
    end else if (do_pop) begin
      count_q <= count_m1;
      dout_q  <= mem_q[count_m1[AW-1:0]];
    end
  end

  assign dout_o  = dout_q;
  assign count_o = count_q;

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin arbiter/sequencer: one push or pop per IDLE->EXEC->RESP pass,
// with op/data latched at grant so late requester changes cannot disturb it.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  stack_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    state_q, state_d;
  logic          rr_q, rr_d;
  logic          win_q, win_d;
  logic          op_q, op_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    nack_q, nack_d;

  logic          winner;
  logic          push_en;
  logic          pop_en;
  logic [DW-1:0] stk_dout;
  logic [AW:0]   stk_count;
  logic          stk_full;
  logic          stk_empty;

  // rr_q only matters on a tie; a lone requester always wins.
  assign winner  = (bus.req == 2'b11) ? rr_q : bus.req[1];
  assign push_en = (state_q == ST_EXEC) && (op_q == OP_PUSH) && !stk_full;
  assign pop_en  = (state_q == ST_EXEC) && (op_q == OP_POP) && !stk_empty;

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    gnt_d   = 2'b00;
    ack_d   = 2'b00;
    nack_d  = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          win_d   = winner;
          op_d    = bus.op[winner];
          wdata_d = winner ? bus.wdata1 : bus.wdata0;
          rr_d    = ~winner;
          gnt_d   = onehot2(winner);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (push_en || pop_en) ack_d  = onehot2(win_q);
        else                   nack_d = onehot2(win_q);
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      win_q   <= 1'b0;
      op_q    <= OP_POP;
      wdata_q <= '0;
      gnt_q   <= 2'b00;
      ack_q   <= 2'b00;
      nack_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
    end
  end

  lifo_stack #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_en),
    .pop_i   (pop_en),
    .din_i   (wdata_q),
    .dout_o  (stk_dout),
    .count_o (stk_count),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.nack  = nack_q;
  assign bus.rdata = stk_dout;
  assign bus.count = stk_count;
  assign bus.full  = stk_full;
  assign bus.empty = stk_empty;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter (DEPTH=4): a reference stack model feeds a
// response scoreboard that is drained at each ack/nack cycle.
module tb_stack_arbiter;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0]    ack;
    logic [1:0]    nack;
    logic [DW-1:0] rdata;
    logic [2:0]    count;
    logic          full;
    logic          empty;
  } resp_t;

  logic clk = 1'b0;
  logic rst;

  int total = 0;
  int bad   = 0;

  resp_t         sb[$];
  logic [DW-1:0] mdl[$];
  logic [DW-1:0] last_rdata;

  stack_arbiter_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  stack_arbiter #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic resp_t model_step(input int who, input logic opv, input logic [DW-1:0] d);
    resp_t r;
    logic  ok;
    ok = 1'b0;
    if (opv) begin
      if (mdl.size() < DEPTH) begin
        mdl.push_back(d);
        ok = 1'b1;
      end
    end else if (mdl.size() > 0) begin
      last_rdata = mdl.pop_back();
      ok = 1'b1;
    end
    r.ack   = ok ? (2'b01 << who) : 2'b00;
    r.nack  = ok ? 2'b00 : (2'b01 << who);
    r.rdata = last_rdata;
    r.count = 3'(mdl.size());
    r.full  = (mdl.size() == DEPTH);
    r.empty = (mdl.size() == 0);
    return r;
  endfunction

  task automatic compare_resp(input string tag);
    resp_t e;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, ".ack"},   bus.ack,   e.ack);
      check({tag, ".nack"},  bus.nack,  e.nack);
      check({tag, ".rdata"}, bus.rdata, e.rdata);
      check({tag, ".count"}, bus.count, e.count);
      check({tag, ".full"},  bus.full,  e.full);
      check({tag, ".empty"}, bus.empty, e.empty);
      check({tag, ".gnt"},   bus.gnt,   2'b00);
    end
  endtask

  // Starts and ends on a negedge inside an IDLE cycle.
  task automatic run_txn(input string tag, input int who, input logic opv,
                         input logic [DW-1:0] d, input bit drop);
    bus.req[who] = 1'b1;
    bus.op[who]  = opv;
    if (who == 0) bus.wdata0 = d;
    else          bus.wdata1 = d;
    sb.push_back(model_step(who, opv, d));
    @(posedge clk);
    @(negedge clk);
    check({tag, ".gnt"}, bus.gnt, 2'b01 << who);
    check({tag, ".early_resp"}, {bus.ack, bus.nack}, 4'b0000);
    if (drop) begin
      bus.req[who] = 1'b0;
      bus.op[who]  = ~opv;
      if (who == 0) bus.wdata0 = ~d;
      else          bus.wdata1 = ~d;
    end
    @(negedge clk);
    compare_resp(tag);
    bus.req[who] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    bus.req    = 2'b00;
    bus.op     = 2'b00;
    bus.wdata0 = '0;
    bus.wdata1 = '0;
    last_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst.gnt",   bus.gnt,   2'b00);
    check("rst.ack",   bus.ack,   2'b00);
    check("rst.nack",  bus.nack,  2'b00);
    check("rst.rdata", bus.rdata, 8'h00);
    check("rst.count", bus.count, 3'd0);
    check("rst.empty", bus.empty, 1'b1);
    check("rst.full",  bus.full,  1'b0);
    @(negedge clk);
    check("idle.gnt", bus.gnt, 2'b00);

    // contention from reset: requester 0 first, then 1
    bus.req    = 2'b11;
    bus.op     = 2'b11;
    bus.wdata0 = 8'h01;
    bus.wdata1 = 8'h02;
    sb.push_back(model_step(0, 1'b1, 8'h01));
    sb.push_back(model_step(1, 1'b1, 8'h02));
    @(posedge clk);
    @(negedge clk);
    check("cont0.gnt", bus.gnt, 2'b01);
    @(negedge clk);
    compare_resp("cont0");
    bus.req[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("cont1.gnt", bus.gnt, 2'b10);
    @(negedge clk);
    compare_resp("cont1");
    bus.req[1] = 1'b0;
    @(negedge clk);
    run_txn("cont_pop_a", 0, 1'b0, 8'h00, 1'b0);
    run_txn("cont_pop_b", 1, 1'b0, 8'h00, 1'b0);

    // single requester push then pop
    run_txn("single_push", 0, 1'b1, 8'hA5, 1'b0);
    run_txn("single_pop",  0, 1'b0, 8'h00, 1'b0);

    // LIFO order
    run_txn("lifo_push1", 0, 1'b1, 8'h11, 1'b0);
    run_txn("lifo_push2", 1, 1'b1, 8'h22, 1'b0);
    run_txn("lifo_push3", 0, 1'b1, 8'h33, 1'b0);
    run_txn("lifo_pop1",  1, 1'b0, 8'h00, 1'b0);
    run_txn("lifo_pop2",  0, 1'b0, 8'h00, 1'b0);
    run_txn("lifo_pop3",  1, 1'b0, 8'h00, 1'b0);

    // fill past full, then drain past empty
    for (int i = 0; i < DEPTH + 1; i++)
      run_txn($sformatf("fill%0d", i), i % 2, 1'b1, 8'hC0 + 8'(i), 1'b0);
    for (int i = 0; i < DEPTH + 1; i++)
      run_txn($sformatf("drain%0d", i), (i + 1) % 2, 1'b0, 8'h00, 1'b0);

    // reset during EXEC of a push aborts it
    run_txn("pre_rst_push", 0, 1'b1, 8'h44, 1'b0);
    bus.req[1]   = 1'b1;
    bus.op[1]    = 1'b1;
    bus.wdata1   = 8'h77;
    @(posedge clk);
    @(negedge clk);
    check("midrst.gnt", bus.gnt, 2'b10);
    rst = 1'b1;
    bus.req = 2'b00;
    mdl.delete();
    last_rdata = '0;
    #1;
    check("midrst.count_async", bus.count, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("midrst.noresp%0d", i), {bus.ack, bus.nack, bus.gnt}, 6'd0);
      check($sformatf("midrst.count%0d", i), bus.count, 3'd0);
      check($sformatf("midrst.empty%0d", i), bus.empty, 1'b1);
      @(negedge clk);
    end
    check("midrst.rdata", bus.rdata, 8'h00);

    // dropped request still completes with latched op/data
    run_txn("drop_push", 0, 1'b1, 8'h5A, 1'b1);
    run_txn("drop_pop",  1, 1'b0, 8'h00, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
